// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - request/response handshake bundle between the memory stage and data memory
interface dmem_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_mode;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_mode, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_mode, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - RV32I data-memory responder with wait states; DMEM_MISALIGN_ERR_EN turns misalignment into errors
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 1
) (
   input logic   clk,
   input logic   rst_n,
   dmem_if.slave bus
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state, state_nxt;
   logic [3:0]    cnt, cnt_nxt;
   logic          lat_we;
   logic [31:0]   lat_addr, lat_wdata;
   logic [2:0]    lat_mode;
   logic [31:0]   rdata_q;
   logic          err_q;
   logic [31:0]   mem [DEPTH_WORDS];

   logic          a_we;
   logic [31:0]   a_addr, a_wdata;
   logic [2:0]    a_mode;
   logic [AW-1:0] a_idx;
   logic [31:0]   a_word, wr_word, ld_data;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic          a_err, accept, do_access, wr_en;

   // A zero-wait access happens on the acceptance edge, so operands come straight off the bus
   always_comb begin
      a_we    = lat_we;
      a_addr  = lat_addr;
      a_wdata = lat_wdata;
      a_mode  = lat_mode;
      if (state == IDLE) begin
         a_we    = bus.req_we;
         a_addr  = bus.req_addr;
         a_wdata = bus.req_wdata;
         a_mode  = bus.req_mode;
      end
   end

   assign a_idx  = a_addr[2 +: AW];
   assign a_word = mem[a_idx];

   always_comb begin
      a_err = ((a_addr >> (AW + 2)) != 32'd0)
            || (a_mode == 3'b011) || (a_mode[2:1] == 2'b11)
            || (a_we && a_mode[2]);
`ifdef DMEM_MISALIGN_ERR_EN
      if ((a_mode[1:0] == 2'b01 && a_addr[0]) || (a_mode == 3'b010 && a_addr[1:0] != 2'b00))
         a_err = 1'b1;
`endif
   end

   // Without the misalignment check, low address bits below the access size are simply ignored
   always_comb begin
      byte_sel = a_word[{a_addr[1:0], 3'b000} +: 8];
      half_sel = a_addr[1] ? a_word[31:16] : a_word[15:0];
      case (a_mode)
         3'b000:  ld_data = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  ld_data = {{16{half_sel[15]}}, half_sel};
         3'b100:  ld_data = {24'd0, byte_sel};
         3'b101:  ld_data = {16'd0, half_sel};
         default: ld_data = a_word;
      endcase
   end

   always_comb begin
      wr_word = a_word;
      case (a_mode[1:0])
         2'b00:   wr_word[{a_addr[1:0], 3'b000} +: 8] = a_wdata[7:0];
         2'b01:   if (a_addr[1]) wr_word[31:16] = a_wdata[15:0];
                  else           wr_word[15:0]  = a_wdata[15:0];
         default: wr_word = a_wdata;
      endcase
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      do_access = 1'b0;
      case (state)
         IDLE: if (bus.req_valid) begin
            accept = 1'b1;
            if (WAIT_STATES == 0) begin
               do_access = 1'b1;
               state_nxt = RESP;
            end else begin
               cnt_nxt   = CNT_INIT;
               state_nxt = WAIT;
            end
         end
         WAIT: if (cnt == 4'd0) begin
            do_access = 1'b1;
            state_nxt = RESP;
         end else begin
            cnt_nxt = cnt - 4'd1;
         end
         RESP: if (bus.rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         lat_we    <= 1'b0;
         lat_addr  <= 32'd0;
         lat_wdata <= 32'd0;
         lat_mode  <= 3'd0;
         rdata_q   <= 32'd0;
         err_q     <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            lat_we    <= bus.req_we;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
            lat_mode  <= bus.req_mode;
         end
         if (do_access) begin
            err_q   <= a_err;
            rdata_q <= (a_err || a_we) ? 32'd0 : ld_data;
         end
      end
   end

   // rst_n gate keeps a zero-wait store from committing while reset is held
   assign wr_en = do_access && a_we && !a_err && rst_n;

   always_ff @(posedge clk) begin
      if (wr_en) mem[a_idx] <= wr_word;
   end

   assign bus.req_ready = (state == IDLE);
   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench: WAIT_STATES=1 instance plus a zero-wait instance
module tb_dmem_responder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dmem_if ba ();
   dmem_if bb ();

   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(ba));
   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bb));

   int n_cmp = 0;
   int n_bad = 0;

   // Byte-addressed reference memories, one per instance
   logic [7:0] ref_mem [2][4096];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model(input int s, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] mode, output logic [31:0] rd, output logic er);
      int n;
      logic [31:0] base;
      longint v;
      n = 1; er = 1'b0; rd = 32'd0;
      case (mode)
         3'd0, 3'd4: n = 1;
         3'd1, 3'd5: n = 2;
         3'd2:       n = 4;
         default:    er = 1'b1;
      endcase
      if (addr >= 32'd4096) er = 1'b1;
      if (we && mode[2]) er = 1'b1;
`ifdef DMEM_MISALIGN_ERR_EN
      if (!er && (addr % n) != 0) er = 1'b1;
`endif
      if (er) return;
      base = addr - (addr % n);
      if (we) begin
         for (int i = 0; i < n; i++) ref_mem[s][base + i] = wdata[8*i +: 8];
      end else begin
         v = 0;
         for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[s][base + i]) << (8*i));
         if (!mode[2] && n < 4 && v[8*n-1]) v = v - (64'sd1 << (8*n));
         rd = v[31:0];
      end
   endtask

   // One transaction on the WAIT_STATES=1 instance; hold = cycles of response backpressure
   task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] mode,
                      input int hold, input string tag, output logic [31:0] got);
      logic [31:0] exp_d;
      logic exp_e;
      int lat;
      model(0, we, addr, wdata, mode, exp_d, exp_e);
      @(negedge clk);
      ba.req_valid = 1'b1; ba.req_we = we; ba.req_addr = addr; ba.req_wdata = wdata; ba.req_mode = mode;
      lat = 0;
      while (!ba.req_ready && lat < 20) begin @(negedge clk); lat++; end
      chk({tag, "_acc"}, ba.req_ready, 1);
      @(posedge clk); #1 ba.req_valid = 1'b0;
      lat = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk); lat++;
         if (ba.rsp_valid) break;
      end
      chk({tag, "_lat"}, lat, 2);
      chk({tag, "_rdata"}, ba.rsp_rdata, exp_d);
      chk({tag, "_err"}, ba.rsp_err, exp_e);
      got = ba.rsp_rdata;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk({tag, "_hold_valid"}, ba.rsp_valid, 1);
         chk({tag, "_hold_rdata"}, ba.rsp_rdata, exp_d);
         chk({tag, "_hold_err"}, ba.rsp_err, exp_e);
         chk({tag, "_hold_rdy"}, ba.req_ready, 0);
      end
      ba.rsp_ready = 1'b1;
      @(negedge clk);
      chk({tag, "_drop"}, ba.rsp_valid, 0);
      ba.rsp_ready = 1'b0;
   endtask

   logic [31:0] got;
   logic [31:0] exp_d;
   logic        exp_e;
   logic [31:0] q_d[$];
   logic        q_e[$];
   logic        fire;
   int          acc, rsp, first_c, last_c;

   task automatic gen_b(input int k);
      logic [2:0] modes [5];
      modes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      if (k < 8) begin
         bb.req_we = 1'b1; bb.req_addr = 32'(4*k); bb.req_mode = 3'd2;
      end else begin
         bb.req_we = 1'($urandom_range(0, 1)); bb.req_addr = 32'($urandom_range(0, 31));
         bb.req_mode = modes[$urandom_range(0, 4)];
      end
      bb.req_wdata = $urandom;
   endtask

   initial begin
      ba.req_valid = 0; ba.req_we = 0; ba.req_addr = 0; ba.req_wdata = 0; ba.req_mode = 0; ba.rsp_ready = 0;
      bb.req_valid = 0; bb.req_we = 0; bb.req_addr = 0; bb.req_wdata = 0; bb.req_mode = 0; bb.rsp_ready = 0;
      #1;
      chk("rst_req_ready", ba.req_ready, 1);
      chk("rst_rsp_valid", ba.rsp_valid, 0);
      chk("rst_rdata", ba.rsp_rdata, 0);
      chk("rst_err", ba.rsp_err, 0);
      chk("rst0_req_ready", bb.req_ready, 1);
      chk("rst0_rsp_valid", bb.rsp_valid, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int w = 0; w < 64; w++) txn(1'b1, 32'(4*w), $urandom, 3'd2, 0, "init", got);

      txn(1'b1, 32'h10, 32'hDEADBEEF, 3'd2, 0, "sw10", got);
      txn(1'b0, 32'h10, 32'h0, 3'd2, 0, "lw10", got);
      chk("lw10_const", got, 32'hDEADBEEF);
      txn(1'b1, 32'h11, 32'h7F, 3'd0, 0, "sb11", got);
      txn(1'b0, 32'h10, 32'h0, 3'd2, 0, "lw10b", got);
      chk("lw10b_const", got, 32'hDEAD7FEF);
      txn(1'b0, 32'h13, 32'h0, 3'd0, 0, "lb13", got);
      chk("lb13_const", got, 32'hFFFFFFDE);
      txn(1'b0, 32'h13, 32'h0, 3'd4, 0, "lbu13", got);
      chk("lbu13_const", got, 32'h000000DE);
      txn(1'b0, 32'h12, 32'h0, 3'd1, 0, "lh12", got);
      chk("lh12_const", got, 32'hFFFFDEAD);
      txn(1'b0, 32'h10, 32'h0, 3'd5, 0, "lhu10", got);
      chk("lhu10_const", got, 32'h00007FEF);

      txn(1'b0, 32'h10, 32'h0, 3'd2, 5, "bp", got);

      txn(1'b1, 32'h1000, 32'h12345678, 3'd2, 0, "sw_oor", got);
      txn(1'b0, 32'h0, 32'h0, 3'd2, 0, "lw0_unch", got);
      txn(1'b0, 32'h10, 32'h0, 3'd3, 0, "mode011", got);
      txn(1'b1, 32'h14, 32'h0, 3'd4, 0, "sbu_err", got);
      txn(1'b0, 32'h12, 32'h0, 3'd2, 0, "lw12_mis", got);
      txn(1'b0, 32'h11, 32'h0, 3'd1, 0, "lh11_mis", got);

      // Reset while the store sits in WAIT: it must never commit
      txn(1'b0, 32'h10, 32'h0, 3'd2, 0, "pre_rst", got);
      @(negedge clk);
      ba.req_valid = 1'b1; ba.req_we = 1'b1; ba.req_addr = 32'h20; ba.req_wdata = 32'h55; ba.req_mode = 3'd2;
      @(posedge clk); #1 ba.req_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_req_ready", ba.req_ready, 1);
      chk("mid_rst_rsp_valid", ba.rsp_valid, 0);
      chk("mid_rst_rdata", ba.rsp_rdata, 0);
      chk("mid_rst_err", ba.rsp_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      txn(1'b0, 32'h20, 32'h0, 3'd2, 0, "lw20_old", got);

      for (int r = 0; r < 80; r++) begin
         logic [31:0] ra;
         ra = ($urandom_range(0, 9) == 0) ? 32'h1000 + 32'($urandom_range(0, 255)) : 32'($urandom_range(0, 255));
         txn(1'($urandom_range(0, 1)), ra, $urandom, 3'($urandom_range(0, 7)), int'($urandom_range(0, 2)), "rnd", got);
      end

      // Zero-wait instance: back-to-back stream, one transaction every two cycles
      acc = 0; rsp = 0; first_c = -1; last_c = -1;
      @(negedge clk);
      bb.rsp_ready = 1'b1;
      gen_b(0);
      bb.req_valid = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bb.rsp_valid && q_d.size() > 0) begin
            chk("b2b_rdata", bb.rsp_rdata, q_d.pop_front());
            chk("b2b_err", bb.rsp_err, q_e.pop_front());
            rsp++;
         end
         fire = bb.req_valid && bb.req_ready;
         if (fire) begin
            model(1, bb.req_we, bb.req_addr, bb.req_wdata, bb.req_mode, exp_d, exp_e);
            q_d.push_back(exp_d);
            q_e.push_back(exp_e);
            acc++;
            if (first_c < 0) first_c = c;
            last_c = c;
         end
         @(posedge clk); #1;
         if (fire) begin
            if (acc < 16) gen_b(acc);
            else bb.req_valid = 1'b0;
         end
      end
      chk("b2b_accepts", acc, 16);
      chk("b2b_responses", rsp, 16);
      chk("b2b_span", last_c - first_c, 30);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
